// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, timing defaults, command bytes.
// Also used by the keyboard decoder.
package ps2_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SEND,
        S_ACK,
        S_RELEASE
    } host_state_e;

    localparam int unsigned INHIBIT_CYCLES_DEF = 10000;    // 100 us at 100 MHz
    localparam int unsigned TIMEOUT_CYCLES_DEF = 2000000;  // 20 ms at 100 MHz

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    // PS/2 frames carry odd parity over the data byte
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and frame status between a requester and ps2_host_tx.
interface ps2_host_tx_if;
    logic       send_valid;
    logic [7:0] send_data;
    logic       send_ready;
    logic       busy;
    logic       done;
    logic       ack_error;

    modport master (output send_valid, send_data, input send_ready, busy, done, ack_error);
    modport slave  (input send_valid, send_data, output send_ready, busy, done, ack_error);
endinterface

// File: rtl/ps2_host_tx_line_sync.sv
// 2-FF synchronizers for the raw PS/2 clock and data lines plus clock falling-edge detect.
module ps2_line_sync (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clock,
    input  logic ps2_data,
    output logic clock_s,
    output logic data_s,
    output logic clock_fall
);
    // bit 0 = clock line, bit 1 = data line; idle bus level is 1
    logic [1:0] meta;
    logic [1:0] sync;
    logic       clock_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta       <= 2'b11;
            sync       <= 2'b11;
            clock_prev <= 1'b1;
        end else begin
            meta       <= {ps2_data, ps2_clock};
            sync       <= meta;
            clock_prev <= sync[0];
        end
    end

    assign clock_s    = sync[0];
    assign data_s     = sync[1];
    assign clock_fall = clock_prev & ~sync[0];
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 8 data + parity + stop, ACK.
// Optional frame watchdog enabled by defining PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ps2_clock,
    input  logic          ps2_data,
    output logic          ps2_clock_oe,
    output logic          ps2_data_oe,
    ps2_host_tx_if.slave  host
);
    localparam int CNT_W = $clog2(INHIBIT_CYCLES + 1);

    host_state_e state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_idx;
    logic [7:0]       data_q;
    logic             parity_q;
    logic             ack_q;
    logic             ready_q, busy_q, done_q, err_q;
    logic             clock_s, data_s, clock_fall;

    ps2_line_sync u_sync (
        .clock      (clock),
        .reset      (reset),
        .ps2_clock  (ps2_clock),
        .ps2_data   (ps2_data),
        .clock_s    (clock_s),
        .data_s     (data_s),
        .clock_fall (clock_fall)
    );

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            ps2_clock_oe <= 1'b0;
            ps2_data_oe  <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cnt          <= '0;
            bit_idx      <= '0;
            data_q       <= '0;
            parity_q     <= 1'b0;
            ack_q        <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            wd           <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    ps2_clock_oe <= 1'b0;
                    ps2_data_oe  <= 1'b0;
                    // ready is held low through the done cycle, so no same-cycle re-accept
                    ready_q      <= 1'b1;
                    if (host.send_valid && ready_q) begin
                        data_q       <= host.send_data;
                        parity_q     <= odd_parity(host.send_data);
                        cnt          <= '0;
                        ps2_clock_oe <= 1'b1;
                        ready_q      <= 1'b0;
                        busy_q       <= 1'b1;
                        state        <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                        ps2_data_oe <= 1'b1;
                        state       <= S_START;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_START: begin
                    // release clock with data held low: start bit / request-to-send
                    ps2_clock_oe <= 1'b0;
                    bit_idx      <= '0;
                    state        <= S_SEND;
                end
                S_SEND: begin
                    if (clock_fall) begin
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx < 4'd8) begin
                            ps2_data_oe <= ~data_q[bit_idx[2:0]];
                        end else if (bit_idx == 4'd8) begin
                            ps2_data_oe <= ~parity_q;
                        end else begin
                            ps2_data_oe <= 1'b0;
                            state       <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    if (clock_fall) begin
                        ack_q <= data_s;
                        state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (clock_s && data_s) begin
                        done_q <= 1'b1;
                        err_q  <= ack_q;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
            // watchdog overrides the case above when the device stops clocking
            if (state == S_SEND || state == S_ACK || state == S_RELEASE) begin
                if (clock_fall) begin
                    wd <= '0;
                end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    wd           <= '0;
                    ps2_clock_oe <= 1'b0;
                    ps2_data_oe  <= 1'b0;
                    done_q       <= 1'b1;
                    err_q        <= 1'b1;
                    busy_q       <= 1'b0;
                    state        <= S_IDLE;
                end else begin
                    wd <= wd + 1'b1;
                end
            end else begin
                wd <= '0;
            end
`endif
        end
    end

    assign host.send_ready = ready_q;
    assign host.busy       = busy_q;
    assign host.done       = done_q;
    assign host.ack_error  = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: PS/2 device model, expected-frame and expected-done scoreboards.
module tb_ps2_host_tx;
    localparam int INH  = 100;
    localparam int TO   = 2000;
    localparam int HALF = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic clock_oe, data_oe;
    logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
    wire  ps2_clock = ~(clock_oe | dev_clk_low);
    wire  ps2_data  = ~(data_oe | dev_data_low);

    ps2_host_tx_if bus ();

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clock        (clk),
        .reset        (rst),
        .ps2_clock    (ps2_clock),
        .ps2_data     (ps2_data),
        .ps2_clock_oe (clock_oe),
        .ps2_data_oe  (data_oe),
        .host         (bus)
    );

    int checks = 0, errors = 0;
    int cyc = 0, send_cyc = 0, last_done = 0;
    bit chk_gap = 0, chk_to = 0;
    bit dev_en = 1, dev_ack = 1, dev_kill = 0;
    int dev_falls = 0;
    logic [9:0] exp_frames[$];   // {stop, parity, data}
    bit         exp_done[$];     // expected ack_error per done pulse

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s bound expired", name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // device: waits for request-to-send, clocks 11 times, samples on rising edges
    always begin : device
        logic [9:0] rx;
        bit ok;
        do @(posedge clk); while (!(dev_en && !dev_kill && ps2_data == 1'b0 && ps2_clock == 1'b1));
        ok = 1;
        rx = '0;
        dev_falls = 0;
        for (int i = 0; i < 11 && ok; i++) begin
            if (i == 10 && dev_ack) dev_data_low = 1'b1;
            repeat (HALF) @(posedge clk);
            if (dev_kill) ok = 0;
            if (ok) begin
                dev_clk_low = 1'b1;
                dev_falls++;
            end
            repeat (HALF) @(posedge clk);
            if (dev_kill) ok = 0;
            dev_clk_low = 1'b0;
            if (ok && i < 10) rx[i] = ps2_data;
        end
        repeat (4) @(posedge clk);
        dev_data_low = 1'b0;
        dev_clk_low  = 1'b0;
        if (ok) begin
            chk("frame_expected", int'(exp_frames.size() > 0), 1);
            if (exp_frames.size() > 0) chk("frame_bits", rx, exp_frames.pop_front());
        end
    end

    // done monitor and line-shape monitor
    int inh_run = 0, st_run = 0;
    always @(negedge clk) begin
        if (bus.done) begin
            chk("done_expected", int'(exp_done.size() > 0), 1);
            if (exp_done.size() > 0) chk("ack_error", bus.ack_error, exp_done.pop_front());
            chk("done_clock_released", clock_oe, 0);
            chk("done_data_released", data_oe, 0);
            chk("ready_low_on_done", bus.send_ready, 0);
            if (chk_to) chk("timeout_latency", cyc - send_cyc, TO);
            last_done = cyc;
        end
        if (rst) begin
            inh_run = 0;
            st_run  = 0;
        end else begin
            if (clock_oe && !data_oe) begin
                if (inh_run == 0 && chk_gap) begin
                    chk("b2b_gap", cyc - last_done, 2);
                    chk_gap = 0;
                end
                inh_run++;
            end else if (inh_run != 0) begin
                chk("inhibit_len", inh_run, INH);
                inh_run = 0;
            end
            if (clock_oe && data_oe) st_run++;
            else if (st_run != 0) begin
                chk("start_len", st_run, 1);
                st_run = 0;
                if (!clock_oe && data_oe) send_cyc = cyc;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bus.send_data  = b;
        bus.send_valid = 1'b1;
        while (!bus.send_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.send_ready) fail_now("accept");
        @(posedge clk);
        #1 bus.send_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while ((exp_done.size() != 0 || exp_frames.size() != 0 || bus.busy) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound) fail_now(name);
    endtask

    task automatic wait_falls(input int k);
        int n = 0;
        while (dev_falls < k && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (dev_falls < k) fail_now("wait_falls");
    endtask

    initial begin
        bus.send_valid = 1'b0;
        bus.send_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_clock_oe", clock_oe, 0);
        chk("rst_data_oe", data_oe, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ack_error", bus.ack_error, 0);
        chk("rst_ready", bus.send_ready, 1);
        rst = 1'b0;

        // 0xED acked: bits 1,0,1,1,0,1,1,1 parity 1 stop 1
        exp_frames.push_back(10'b1_1_11101101);
        exp_done.push_back(1'b0);
        send(8'hED);
        wait_idle("ed_frame", 5000);

        // 0x00 with no ACK
        dev_ack = 0;
        exp_frames.push_back(10'b1_1_00000000);
        exp_done.push_back(1'b1);
        send(8'h00);
        wait_idle("noack_frame", 5000);
        dev_ack = 1;
        chk("noack_clock_released", ps2_clock, 1);
        chk("noack_data_released", ps2_data, 1);

        // 0x55 pulsed mid-frame is ignored
        exp_frames.push_back(10'b1_1_11101101);
        exp_done.push_back(1'b0);
        dev_falls = 0;
        send(8'hED);
        wait_falls(3);
        @(negedge clk);
        bus.send_data  = 8'h55;
        bus.send_valid = 1'b1;
        chk("busy_ready_low", bus.send_ready, 0);
        chk("busy_high", bus.busy, 1);
        @(negedge clk);
        bus.send_valid = 1'b0;
        wait_idle("ignore_frame", 5000);

        // reset after the 4th falling edge
        exp_frames.push_back(10'b1_1_11101101);
        exp_done.push_back(1'b0);
        dev_falls = 0;
        send(8'hED);
        wait_falls(4);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        dev_kill = 1;
        #1;
        chk("async_clock_oe", clock_oe, 0);
        chk("async_data_oe", data_oe, 0);
        exp_frames.delete();
        exp_done.delete();
        repeat (2 * HALF + 8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", bus.send_ready, 1);
        chk("post_rst_busy", bus.busy, 0);
        dev_kill = 0;

        // 0xF4: parity 0
        exp_frames.push_back(10'b1_0_11110100);
        exp_done.push_back(1'b0);
        send(8'hF4);
        wait_idle("f4_frame", 5000);

        // back-to-back 0xED then 0x02 with valid held high
        exp_frames.push_back(10'b1_1_11101101);
        exp_frames.push_back(10'b1_0_00000010);
        exp_done.push_back(1'b0);
        exp_done.push_back(1'b0);
        @(negedge clk);
        bus.send_data  = 8'hED;
        bus.send_valid = 1'b1;
        @(posedge clk);
        #1 bus.send_data = 8'h02;
        begin
            int n = 0;
            while (exp_done.size() > 1 && n < 5000) begin
                @(negedge clk);
                n++;
            end
            if (exp_done.size() > 1) fail_now("b2b_first_done");
        end
        chk_gap = 1;
        begin
            int n = 0;
            while (!bus.busy && n < 10) begin
                @(negedge clk);
                n++;
            end
            if (!bus.busy) fail_now("b2b_second_accept");
        end
        bus.send_valid = 1'b0;
        wait_idle("b2b_frames", 5000);

        // device never clocks
        dev_en = 0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
        exp_done.push_back(1'b1);
        chk_to = 1;
        send(8'h55);
        wait_idle("timeout_done", TO + INH + 500);
        chk_to = 0;
`else
        send(8'h55);
        begin
            int low = 0;
            repeat (TO + 200) begin
                @(negedge clk);
                if (!bus.busy) low++;
            end
            chk("busy_held", low, 0);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("stuck_rst_busy", bus.busy, 0);
`endif
        dev_en = 1;
        repeat (10) @(negedge clk);
        chk("frames_left", exp_frames.size(), 0);
        chk("done_left", exp_done.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 10000, clock-low inhibit time in clock cycles (100 us at 100 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 2000000, frame watchdog limit in clock cycles (20 ms).
REQ-003 clock  in  1  system clock (100 MHz domain, same clock as the keyboard decoder).
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ps2_clock  in  1  raw PS/2 clock line, unsynchronized.
REQ-006 ps2_data  in  1  raw PS/2 data line, unsynchronized.
REQ-007 ps2_clock_oe  out  1  1 = pull PS/2 clock low; 0 = release.
REQ-008 ps2_data_oe  out  1  1 = pull PS/2 data low; 0 = release.
REQ-009 send_valid  in  1  request to transmit send_data.
REQ-010 send_data  in  8  command byte to send to the device.
REQ-011 send_ready  out  1  high only in IDLE; a transfer occurs when send_valid and send_ready are both high on a clock edge.
REQ-012 busy  out  1  high in every state except IDLE; the keyboard decoder uses it to discard frames.
REQ-013 done  out  1  single-cycle pulse at frame completion.
REQ-014 ack_error  out  1  valid while done is high; 1 = no ACK or timeout.

Function
REQ-015 ps2_clock and ps2_data SHALL pass through 2-FF synchronizers; a falling edge means the synchronized value was 1 in the previous cycle and is 0 in the current cycle.
REQ-016 States: IDLE, INHIBIT, START, SEND, ACK, RELEASE.
REQ-017 IDLE: both oe = 0. On acceptance, latch send_data, compute odd parity (parity = ~^send_data), clear the counter, and go to INHIBIT.
REQ-018 INHIBIT: ps2_clock_oe = 1 for exactly INHIBIT_CYCLES cycles, then go to START.
REQ-019 START: ps2_clock_oe = 1 and ps2_data_oe = 1 for exactly 1 cycle, then go to SEND.
REQ-020 SEND: ps2_clock_oe = 0 and ps2_data_oe = 1 on entry (start bit). The 4-bit bit_idx SHALL advance on each falling edge:
  - edges 1..8: ps2_data_oe = ~data[bit_idx], LSB first;
  - edge 9: ps2_data_oe = ~parity;
  - edge 10: ps2_data_oe = 0 (stop bit), then go to ACK.
REQ-021 ACK: on the next falling edge, sample synchronized ps2_data; 0 = ACK, 1 = error. Latch the result and go to RELEASE.
REQ-022 RELEASE: wait until both synchronized lines are 1, then pulse done for 1 cycle with ack_error = latched value and return to IDLE.
REQ-023 send_valid while busy SHALL be ignored; no queuing.
REQ-024 send_valid in the cycle that done is high SHALL NOT be accepted; send_ready rises in the following cycle.
REQ-025 outputs are registered, and oe changes occur 1 cycle after the detected edge; latency from the 10th falling edge to stop release is 1 cycle.

Reset
REQ-026 Reset SHALL force IDLE, both oe = 0, done = 0, ack_error = 0, busy = 0, and clear all counters; the synchronizers reset to 1.
REQ-027 Reset during any state SHALL release both lines immediately (asynchronously); no done pulse is produced.

Configuration
REQ-028 Macro PS2_HOST_TX_TIMEOUT_EN defined: a counter runs from entry into SEND. It resets on each falling edge. Reaching TIMEOUT_CYCLES in SEND, ACK or RELEASE SHALL release both lines, pulse done with ack_error = 1, and go to IDLE.
REQ-029 Without the macro: no watchdog logic exists, and the FSM waits indefinitely for device clocks.

Structure
REQ-030 The state enum, INHIBIT_CYCLES and TIMEOUT_CYCLES defaults, and the PS/2 command constants (0xED set-LEDs, 0xFF reset, 0xF4 enable) SHALL reside in a shared package ps2_pkg, also used by Keyboard_Decoder.
REQ-031 One sub-module, ps2_line_sync, SHALL provide synchronization and falling-edge detection for both lines.

Verification (bench includes a PS/2 device model, 12.5 kHz clock)
REQ-032 send 0xED, device ACKs: clock_oe high exactly 10000 cycles; sampled bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done = 1 with ack_error = 0.
REQ-033 send 0x00, device holds data high at ACK: parity bit 1; done with ack_error = 1; lines released.
REQ-034 send_valid pulsed with 0x55 during an active 0xED frame: ignored; the device receives only 0xED; no second done pulse.
REQ-035 reset asserted after the 4th falling edge: both oe = 0 in the same cycle, state IDLE, send_ready = 1 after reset deasserts; the next 0xF4 frame is correct.
REQ-036 macro on, device never clocks: done with ack_error = 1 exactly TIMEOUT_CYCLES cycles after entering SEND; macro off: busy stays 1 until reset.
REQ-037 back-to-back sends 0xED then 0x02 with send_valid held high: the second is accepted the cycle after done; the two frames are separated by a full inhibit.
